alu_seq: RTL
============

Name: alu_seq

Overview:
- Registered, multi-cycle successor to the lab's combinational N-bit ALU.
- Same 4-bit opcode set and C/N/V/Z flag semantics.
- Operands and opcode are captured on a start/ready handshake.
- Multiply and divide run iteratively over N cycles; single-cycle ops complete in one cycle.
- Result, flags and the 7-segment pattern are held in registers until the next completion. The block drives the board display directly.

Parameters:
- N, 4, operand/result width (N >= 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- a  in  N  operand A.
- b  in  N  operand B; shift amount for shift ops.
- operation  in  4  opcode.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse when result/flags update.
- result  out  N  registered result.
- outFlagC, outFlagN, outFlagV, outFlagZ  out  1 each  registered flags.
- segA  out  7  active-low segment pattern (g..a) of result[3:0].

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (any state, including mid-iteration):
  - state=IDLE, ready=1, done=0, result=0, all flags=0, segA=7'b1000000 (digit 0).
  - The partial operation is discarded.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT A, 5 NOT B, 6 XOR.
  - 7 ASHL, 8 ASHR, 9 LSHL, 10 LSHR, 11 MUL, 12 DIV.
  - 13-15 are illegal.
- FSM: IDLE, MUL, DIV, DONE.
  - IDLE & start & op in {11,12}: a, b, op latched, iteration counter=0 -> MUL/DIV.
  - IDLE & start & other op: result computed from the latched values -> DONE.
  - MUL/DIV: one iteration per cycle; after N iterations -> DONE.
  - DONE: done=1 for exactly one cycle, outputs update on entry -> IDLE.
- Latency, with start sampled in cycle 0:
  - Single-cycle ops: done=1 in cycle 1.
  - MUL/DIV: done=1 in cycle N+1.
- start while ready=0 is ignored; a/b/operation changes after acceptance have no effect.
- result, flags and segA hold their value between done pulses.
- ADD: result = a+b mod 2^N; C = carry-out; V = signed overflow.
- SUB: result = a-b mod 2^N; C = 1 iff a>=b unsigned (no borrow); V = signed overflow.
- Logic ops: C=0, V=0.
- Shifts: amount = b unsigned; C=0, V=0.
  - Amount >= N: LSHL/LSHR/ASHL give 0; ASHR gives all copies of a[N-1].
  - ASHL is identical to LSHL.
- MUL: unsigned shift-add over 2N-bit product; result = low N bits; C = V = (high N bits != 0).
- DIV: unsigned restoring division; result = quotient; C=0, V=0.
- Illegal opcode: single-cycle; result=0, C=N=V=0, Z=1.
- All ops: N = result[N-1]; Z = (result==0).
- segA: hex decode of result[3:0], 0-F, active low; registered with result.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined:
  - DIV as above.
  - b==0 is detected in IDLE and completes single-cycle (done in cycle 1) with result all ones, V=1, C=0, N=1, Z=0. The DIV state is not entered.
- Undefined:
  - No divider hardware; DIV state is absent.
  - Opcode 12 is single-cycle with result=0, V=1, Z=1, C=0, N=0.

Decomposition:
- Package alu_seq_pkg:
  - opcode enum (OP_ADD..OP_DIV).
  - state enum.
  - 16-entry active-low hex-to-segment constant table / function.
- Sub-module alu_seq_muldiv:
  - shift-add / restoring-divide datapath with internal counter.
  - Inputs: load, op select, a, b.
  - Outputs: N-bit quotient/product-low, product-high-nonzero, finish.
  - The top keeps the FSM, single-cycle ops, flag logic and output registers.

Test Plan (N=4):
- ADD 7+9 -> result 0, C=1, Z=1, V=0, N=0; done in cycle 1; segA=7'b1000000.
- SUB 3-5 -> 0xE, N=1, C=0, V=0; SUB 7-(-8) (b=8) -> 0xF, V=1, C=0.
- MUL 5*3 -> 0xF, C=V=0; MUL 6*3 -> 0x2, C=V=1. done exactly in cycle 5, ready=0 cycles 1-4, start pulses in cycles 1-4 ignored.
- DIV 13/4 -> 3, done in cycle 5. With ALU_SEQ_DIV_EN, DIV 9/0 -> 0xF, V=1, done in cycle 1.
- ASHR 0x8 by 1 -> 0xC; LSHR 0x8 by 1 -> 0x4; LSHL 0x3 by 5 -> 0; ASHR 0x9 by 7 -> 0xF; opcode 14 -> 0, Z=1.
- rst asserted in cycle 2 of MUL 7*7 -> cycle 3: ready=1, result=0, flags 0, no done pulse. A new ADD 1+1 then gives 0x2 in cycle 1 after its start.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: opcodes, FSM states and the active-low hex display decode.
// The DIV state only exists when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOTA = 4'd4,
    OP_NOTB = 4'd5,
    OP_XOR  = 4'd6,
    OP_ASHL = 4'd7,
    OP_ASHR = 4'd8,
    OP_LSHL = 4'd9,
    OP_LSHR = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIV  = 4'd12
  } op_e;

`ifdef ALU_SEQ_DIV_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DONE = 2'd3} state_e;
`endif

  // Segment order is g..a, a lit segment is 0.
  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of alu_seq: operands and opcode in, result, flags and display out.
interface alu_seq_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   operation;
  logic         ready;
  logic         done;
  logic [N-1:0] result;
  logic         outFlagC;
  logic         outFlagN;
  logic         outFlagV;
  logic         outFlagZ;
  logic [6:0]   segA;

  modport master (
    output start, a, b, operation,
    input  ready, done, result, outFlagC, outFlagN, outFlagV, outFlagZ, segA
  );

  modport slave (
    input  start, a, b, operation,
    output ready, done, result, outFlagC, outFlagN, outFlagV, outFlagZ, segA
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle, N cycles.
// Divider logic is only built when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] res,
  output logic         hi_nz,
  output logic         finish
);
  localparam int CW = $clog2(N);

  // acc: product high half / partial remainder; q: multiplier -> product low / dividend -> quotient
  logic [N-1:0]  acc, q, opb, acc_n, q_n;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [N:0]    sum;

`ifdef ALU_SEQ_DIV_EN
  logic          div_q;
  logic [N:0]    rsh, diff;
`else
  logic          unused_div;
  assign unused_div = is_div;
`endif

  always_comb begin
    sum   = {1'b0, acc} + {1'b0, (q[0] ? opb : '0)};
    acc_n = sum[N:1];
    q_n   = {sum[0], q[N-1:1]};
`ifdef ALU_SEQ_DIV_EN
    rsh  = {acc, q[N-1]};
    diff = rsh - {1'b0, opb};
    if (div_q) begin
      // acc < divisor always holds, so diff[N] alone tells whether the trial subtract fits
      if (!diff[N]) begin
        acc_n = diff[N-1:0];
        q_n   = {q[N-2:0], 1'b1};
      end else begin
        acc_n = rsh[N-1:0];
        q_n   = {q[N-2:0], 1'b0};
      end
    end
`endif
  end

  assign finish = busy && (cnt == CW'(N-1));
  assign res    = q_n;
  assign hi_nz  = |acc_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      q    <= '0;
      opb  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (load) begin
      acc  <= '0;
      q    <= a;
      opb  <= b;
      cnt  <= '0;
      busy <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
      div_q <= is_div;
`endif
    end else if (busy) begin
      acc <= acc_n;
      q   <= q_n;
      cnt <= cnt + 1'b1;
      if (finish) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: handshake FSM, single-cycle ops, flags and display registers.
// Define ALU_SEQ_DIV_EN to build the iterative divider; otherwise DIV reports V=1, result 0.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  state_e       state, nxt;
  logic         ld, md_load, md_fin, md_hi;
  logic [N-1:0] md_res;
  logic [N-1:0] sc_res, nres, sub_w;
  logic [N:0]   add_w;
  logic         sc_c, sc_v, nc, nv;
  logic [N-1:0] res_q;
  logic         c_q, n_q, v_q, z_q;
  logic [6:0]   seg_q;

  alu_seq_muldiv #(.N(N)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .load   (md_load),
    .is_div (bus.operation == OP_DIV),
    .a      (bus.a),
    .b      (bus.b),
    .res    (md_res),
    .hi_nz  (md_hi),
    .finish (md_fin)
  );

  always_comb begin
    add_w  = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w  = bus.a - bus.b;
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.operation)
      OP_ADD: begin
        sc_res = add_w[N-1:0];
        sc_c   = add_w[N];
        sc_v   = (bus.a[N-1] == bus.b[N-1]) && (add_w[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        sc_res = sub_w;
        sc_c   = (bus.a >= bus.b);
        sc_v   = (bus.a[N-1] != bus.b[N-1]) && (sub_w[N-1] != bus.a[N-1]);
      end
      OP_AND:          sc_res = bus.a & bus.b;
      OP_OR:           sc_res = bus.a | bus.b;
      OP_NOTA:         sc_res = ~bus.a;
      OP_NOTB:         sc_res = ~bus.b;
      OP_XOR:          sc_res = bus.a ^ bus.b;
      // Verilog shifts already saturate to 0 / sign fill for amounts >= N
      OP_ASHL, OP_LSHL: sc_res = bus.a << bus.b;
      OP_ASHR:         sc_res = $signed(bus.a) >>> bus.b;
      OP_LSHR:         sc_res = bus.a >> bus.b;
      OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
        sc_res = '1;
`endif
        sc_v   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt     = state;
    ld      = 1'b0;
    md_load = 1'b0;
    nres    = sc_res;
    nc      = sc_c;
    nv      = sc_v;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.operation == OP_MUL) begin
            md_load = 1'b1;
            nxt     = ST_MUL;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (bus.operation == OP_DIV && bus.b != '0) begin
            md_load = 1'b1;
            nxt     = ST_DIV;
          end
`endif
          else begin
            ld  = 1'b1;
            nxt = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        if (md_fin) begin
          ld   = 1'b1;
          nres = md_res;
          nc   = md_hi;
          nv   = md_hi;
          nxt  = ST_DONE;
        end
      end
`ifdef ALU_SEQ_DIV_EN
      ST_DIV: begin
        if (md_fin) begin
          ld   = 1'b1;
          nres = md_res;
          nc   = 1'b0;
          nv   = 1'b0;
          nxt  = ST_DONE;
        end
      end
`endif
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      res_q <= '0;
      c_q   <= 1'b0;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
      z_q   <= 1'b0;
      seg_q <= hex2seg(4'h0);
    end else begin
      state <= nxt;
      if (ld) begin
        res_q <= nres;
        c_q   <= nc;
        n_q   <= nres[N-1];
        v_q   <= nv;
        z_q   <= (nres == '0);
        seg_q <= hex2seg(4'(nres));
      end
    end
  end

  assign bus.ready    = (state == ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.result   = res_q;
  assign bus.outFlagC = c_q;
  assign bus.outFlagN = n_q;
  assign bus.outFlagV = v_q;
  assign bus.outFlagZ = z_q;
  assign bus.segA     = seg_q;
endmodule
